// File: rtl/hft_pkg.sv
// Fixed-point definitions shared across the market-making datapath.
// Prices and spreads are signed Q32.32 words.
package hft_pkg;

  localparam int FP_WORD_SIZE = 64;
  localparam int FRAC_BITS    = 32;

  typedef logic signed [FP_WORD_SIZE-1:0] fp_t;
  // One guard bit, so that the sum or difference of two words never wraps.
  typedef logic signed [FP_WORD_SIZE:0]   fp_ext_t;

  localparam fp_t ONE = fp_t'(1) <<< FRAC_BITS;

  typedef enum logic {
    ROUND_FLOOR,
    ROUND_CEIL
  } round_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ROUND,
    ST_HOLD
  } quote_state_t;

  // Aligns a value to a multiple of 2^shift. The caller must leave headroom
  // for the ceiling adjustment.
  function automatic fp_ext_t tick_round(input fp_ext_t     value,
                                         input int          shift,
                                         input round_mode_t mode);
    fp_ext_t mask;
    mask = (fp_ext_t'(1) <<< shift) - fp_ext_t'(1);
    if (mode == ROUND_CEIL) value = value + mask;
    return value & ~mask;
  endfunction

endpackage

// File: rtl/operand_capture.sv
// Holding register for one operand stream: keeps the latest value, a "fresh"
// flag, and a one-cycle overrun pulse when a flagged value is overwritten.
module operand_capture #(
  parameter int FP_WORD_SIZE = hft_pkg::FP_WORD_SIZE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic signed [FP_WORD_SIZE-1:0] i_data,
  input  logic                           i_valid,
  input  logic                           i_take,
  output logic                           o_avail,
  output logic signed [FP_WORD_SIZE-1:0] o_operand,
  output logic                           o_overrun
);

  logic signed [FP_WORD_SIZE-1:0] data_q;
  logic                           flag_q;

  // A registered value takes priority. A value arriving on the take edge is
  // forwarded only when nothing was registered; otherwise it is kept for the
  // next quote.
  assign o_avail   = flag_q | i_valid;
  assign o_operand = flag_q ? data_q : i_data;

  // NOTE: non-blocking assignments keep every register update ordered on the clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q    <= '0;
      flag_q    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (i_valid) data_q <= i_data;
      flag_q    <= i_take ? (flag_q & i_valid) : (flag_q | i_valid);
      o_overrun <= i_valid & flag_q & ~i_take;
    end
  end

endmodule

// File: rtl/quote_generator.sv
// Builds a tick-aligned bid/ask pair around the reservation price r with the
// spread s (bid = r - s/2, ask = r + s/2). Each quote is held on a valid/ready handshake.
module quote_generator #(
  parameter int FP_WORD_SIZE = hft_pkg::FP_WORD_SIZE,
  parameter int FRAC_BITS    = hft_pkg::FRAC_BITS,
  parameter int TICK_SHIFT   = FRAC_BITS - 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic signed [FP_WORD_SIZE-1:0] i_spread,
  input  logic                           i_spread_valid,
  input  logic signed [FP_WORD_SIZE-1:0] i_reservation_price,
  input  logic                           i_price_valid,
  output logic signed [FP_WORD_SIZE-1:0] o_bid,
  output logic signed [FP_WORD_SIZE-1:0] o_ask,
  output logic                           o_quote_valid,
  input  logic                           i_quote_ready,
  output logic                           o_overrun
);

  import hft_pkg::*;

  localparam fp_ext_t TICK     = fp_ext_t'(1) <<< TICK_SHIFT;
  localparam fp_ext_t WORD_MAX = (fp_ext_t'(1) <<< (FP_WORD_SIZE - 1)) - fp_ext_t'(1);
  localparam fp_ext_t TICK_MAX = WORD_MAX & ~(TICK - fp_ext_t'(1));

  quote_state_t state_q, state_d;
  logic         take;
  logic         price_avail, spread_avail, pair_ready;
  logic         price_ovr, spread_ovr;
  fp_t          price_cap, spread_cap;
  fp_t          r_w, s_w, s_pos, half;
  fp_ext_t      bid_raw_d, ask_raw_d, bid_raw_q, ask_raw_q;
  fp_ext_t      bid_rnd, ask_rnd;

  operand_capture #(.FP_WORD_SIZE(FP_WORD_SIZE)) u_price_cap (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_reservation_price),
    .i_valid   (i_price_valid),
    .i_take    (take),
    .o_avail   (price_avail),
    .o_operand (price_cap),
    .o_overrun (price_ovr)
  );

  operand_capture #(.FP_WORD_SIZE(FP_WORD_SIZE)) u_spread_cap (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_spread),
    .i_valid   (i_spread_valid),
    .i_take    (take),
    .o_avail   (spread_avail),
    .o_operand (spread_cap),
    .o_overrun (spread_ovr)
  );

  assign pair_ready = price_avail & spread_avail;
  assign o_overrun  = price_ovr | spread_ovr;

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pair_ready) begin
          state_d = ST_CALC;
          take    = 1'b1;
        end
      end
      ST_CALC:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_HOLD;
      ST_HOLD: begin
        if (i_quote_ready) begin
          if (pair_ready) begin
            state_d = ST_CALC;
            take    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A negative spread would cross the quote, so it is treated as zero.
  always_comb begin
    s_pos     = s_w[FP_WORD_SIZE-1] ? '0 : s_w;
    half      = s_pos >>> 1;
    bid_raw_d = fp_ext_t'(r_w) - fp_ext_t'(half);
    ask_raw_d = fp_ext_t'(r_w) + fp_ext_t'(half);
    if (ask_raw_d > WORD_MAX) ask_raw_d = WORD_MAX;
  end

  // The bid is rounded down and the ask up, so both sides stay at least half a spread from r.
  always_comb begin
    bid_rnd = tick_round(bid_raw_q, TICK_SHIFT, ROUND_FLOOR);
    ask_rnd = tick_round(ask_raw_q, TICK_SHIFT, ROUND_CEIL);
    if (bid_rnd < fp_ext_t'(0)) bid_rnd = '0;
    if (ask_rnd > TICK_MAX)     ask_rnd = TICK_MAX;
    if (ask_rnd - bid_rnd < TICK) begin
      // At the top of the range the one-tick gap is made by pulling the bid down.
      if (bid_rnd > TICK_MAX - TICK) begin
        bid_rnd = TICK_MAX - TICK;
        ask_rnd = TICK_MAX;
      end else begin
        ask_rnd = bid_rnd + TICK;
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always written before they are read.
  always_ff @(posedge i_clk) begin
    if (take) begin
      r_w <= price_cap;
      s_w <= spread_cap;
    end
    if (state_q == ST_CALC) begin
      bid_raw_q <= bid_raw_d;
      ask_raw_q <= ask_raw_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      o_bid         <= '0;
      o_ask         <= '0;
      o_quote_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ROUND) begin
        o_bid         <= bid_rnd[FP_WORD_SIZE-1:0];
        o_ask         <= ask_rnd[FP_WORD_SIZE-1:0];
        o_quote_valid <= 1'b1;
      end else if (state_q == ST_HOLD && i_quote_ready) begin
        o_quote_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/quote_generator.md
Name: quote_generator

Overview:
- Consumes the spread stream (Q32.32 spread plus valid pulse) and the reservation-price stream.
- When both operands are present, builds a tick-aligned bid/ask pair: bid = r − s/2 and ask = r + s/2.
- Holds each quote on a valid/ready handshake toward the order-entry stage.
- Sits directly downstream of the spread stage in the market-making datapath.

Parameters:
- FP_WORD_SIZE, 64: width of every price/spread word (signed).
- FRAC_BITS, 32: fractional bits of the fixed-point format (Q32.32).
- TICK_SHIFT, 24: tick size is 2^TICK_SHIFT LSBs. The default 24 gives a tick of 2^-8 = 0.00390625.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_spread  in  FP_WORD_SIZE  signed spread, Q32.32
- i_spread_valid  in  1  one-cycle qualifier for i_spread
- i_reservation_price  in  FP_WORD_SIZE  signed reservation price r, Q32.32
- i_price_valid  in  1  one-cycle qualifier for i_reservation_price
- o_bid  out  FP_WORD_SIZE  signed bid, tick-aligned
- o_ask  out  FP_WORD_SIZE  signed ask, tick-aligned
- o_quote_valid  out  1  quote available
- i_quote_ready  in  1  downstream accepts the quote when o_quote_valid && i_quote_ready
- o_overrun  out  1  one-cycle pulse: an unconsumed operand was overwritten

Behaviour:
Reset and capture:
- Reset (async assert, sync release): state IDLE, both capture flags 0, o_bid = 0, o_ask = 0, o_quote_valid = 0, o_overrun = 0.
- Capture stage runs independently of the FSM. A valid input loads its capture register and sets its flag.
- If the flag is already set when a new valid arrives, the latest value wins and o_overrun pulses the next cycle.
- Both inputs valid in the same cycle with both flags set gives a single o_overrun pulse.

FSM states IDLE, CALC, ROUND, HOLD:
- IDLE → CALC when both flags are set, either registered or being set this cycle. On that edge, snapshot both operands into working registers and clear both flags.
- A valid arriving on that same edge re-sets its flag for the next quote and is not an overrun.
- CALC (1 cycle):
  - s' = max(s, 0); a negative spread is treated as 0.
  - half = s' >>> 1
  - bid_raw = r − half, ask_raw = r + half, both computed at FP_WORD_SIZE+1 bits.
  - ask_raw saturates to the maximum positive word.
- ROUND (1 cycle), with mask = 2^TICK_SHIFT − 1 and tick = 2^TICK_SHIFT:
  - bid = bid_raw & ~mask (floor).
  - ask = (ask_raw + mask) & ~mask (ceil), saturating to the largest tick-aligned positive word.
  - If bid < 0, bid = 0.
  - If ask − bid < tick, ask = bid + tick.
  - Register o_bid/o_ask and set o_quote_valid.
- HOLD: o_bid, o_ask and o_quote_valid are stable until the handshake.
  - On handshake, drop o_quote_valid. Go to CALC if both flags are set, else IDLE; no bubble cycle.
  - Operands arriving during CALC/ROUND/HOLD only affect capture registers, never the quote in flight.

Latency and outputs:
- Latency: operand completing the pair captured at edge E0 → o_quote_valid high after E2.
- Maximum throughput: one quote per 3 cycles.
- o_bid/o_ask keep their last value after the handshake; their value is don't-care while o_quote_valid = 0.
- Reset mid-operation discards captured operands and any held quote immediately.

Decomposition:
- Shared package hft_pkg holds:
  - the fixed-point typedef (signed FP_WORD_SIZE word);
  - FRAC_BITS;
  - the ONE constant (1 << FRAC_BITS);
  - a tick_round function (floor/ceil selectable).
- One natural sub-module: operand_capture. It holds the register, flag and overrun for one stream and is instantiated twice.

Test Plan:
1. r = 100.0 (0x0000_0064_0000_0000), s = 0.5 (0x0000_0000_8000_0000), same cycle, ready = 1 → o_quote_valid high 2 cycles later; bid = 99.75, ask = 100.25; o_overrun = 0.
2. r = 100.0, s = 0.01 → bid = 99.9921875 (floor), ask = 100.0078125 (ceil).
3. r = 100.0, s = 0 and separately s = −0.3 → bid = 100.0, ask = 100.00390625 (min-tick rule).
4. r = −1.0, s = 0.5 → bid = 0, ask = 0x0000_0000_0100_0000 (one tick).
5. Price first, spread 4 cycles later; ready held low 5 cycles; two spread pulses during HOLD → quote stable throughout; exactly one o_overrun pulse, on the second spread. After a new price arrives, the next quote uses the second spread.
6. Assert i_rst during HOLD → o_quote_valid drops immediately; flags cleared. After release, a single new spread alone produces no quote.
